// File: rtl/seq_divide.sv
// seq_divide: iterative restoring shift-subtract divider, one quotient bit per clock
//
// Parameters:
//   WIDTH        operand, quotient and remainder width in bits (>=2)
// Ports:
//   clkin        clock, rising edge
//   rstin        asynchronous active-high reset
//   start        request, sampled only while busy=0
//   dividend_in  dividend, captured on the accepting edge
//   divisor_in   divisor, captured on the accepting edge
//   busy         division in progress
//   ready        result valid, held until the next accepted start
//   quotient     quotient result
//   remainder    remainder result
//   div_by_zero  divisor was zero, valid with ready
// Configuration macro:
//   DIV_SIGNED_EN  two's complement operands, one extra FIX cycle applies the signs
module seq_divide #(
    parameter int WIDTH = 8
) (
    input  logic             clkin,
    input  logic             rstin,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend_in,
    input  logic [WIDTH-1:0] divisor_in,
    output logic             busy,
    output logic             ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
`ifdef DIV_SIGNED_EN
    localparam logic [1:0] FIX  = 2'd3;
    logic dneg, sdiff;
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? -x : x;
    endfunction
`endif
    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] r, q, dvs, dnd;
    logic [WIDTH:0]   sh, t;
    // The partial remainder never reaches the divisor, so WIDTH bits hold it;
    // the extra bit only exists transiently in the shifted value and trial difference.
    assign sh = {r, q[WIDTH-1]};
    assign t  = sh - {1'b0, dvs};
    always_ff @(posedge clkin or posedge rstin) begin
        if (rstin) begin
            state       <= IDLE;
            cnt         <= '0;
            r           <= '0;
            q           <= '0;
            dvs         <= '0;
            dnd         <= '0;
            busy        <= 1'b0;
            ready       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
            dneg        <= 1'b0;
            sdiff       <= 1'b0;
`endif
        end else if (start && !busy) begin
            state       <= RUN;
            busy        <= 1'b1;
            ready       <= 1'b0;
            div_by_zero <= 1'b0;
            cnt         <= CW'(WIDTH);
            r           <= '0;
            dnd         <= dividend_in;
`ifdef DIV_SIGNED_EN
            q           <= mag(dividend_in);
            dvs         <= mag(divisor_in);
            dneg        <= dividend_in[WIDTH-1];
            sdiff       <= dividend_in[WIDTH-1] ^ divisor_in[WIDTH-1];
`else
            q           <= dividend_in;
            dvs         <= divisor_in;
`endif
        end else if (state == RUN) begin
            if (dvs == '0) begin
                quotient    <= '1;
                remainder   <= dnd;
                div_by_zero <= 1'b1;
                ready       <= 1'b1;
                busy        <= 1'b0;
                state       <= DONE;
            end else begin
                // Trial subtract: a clear sign bit means the divisor fits.
                r   <= t[WIDTH] ? sh[WIDTH-1:0] : t[WIDTH-1:0];
                q   <= {q[WIDTH-2:0], ~t[WIDTH]};
                cnt <= cnt - 1'b1;
                if (cnt == CW'(1)) begin
`ifdef DIV_SIGNED_EN
                    state     <= FIX;
`else
                    quotient  <= {q[WIDTH-2:0], ~t[WIDTH]};
                    remainder <= t[WIDTH] ? sh[WIDTH-1:0] : t[WIDTH-1:0];
                    ready     <= 1'b1;
                    busy      <= 1'b0;
                    state     <= DONE;
`endif
                end
            end
        end
`ifdef DIV_SIGNED_EN
        else if (state == FIX) begin
            quotient  <= sdiff ? -q : q;
            remainder <= dneg ? -r : r;
            ready     <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
        end
`endif
    end
endmodule

// File: tb/tb_seq_divide.sv
// tb_seq_divide: scoreboard bench for seq_divide at WIDTH=8
module tb_seq_divide;
    localparam int W = 8;
`ifdef DIV_SIGNED_EN
    localparam int LAT = W + 1;
`else
    localparam int LAT = W;
`endif
    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } res_t;

    logic         clkin = 1'b0;
    logic         rstin = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend_in = '0;
    logic [W-1:0] divisor_in = '0;
    logic         busy, ready, div_by_zero;
    logic [W-1:0] quotient, remainder;
    int           total = 0;
    int           passed = 0;
    res_t         sb[$];
    res_t         exp_r;
    logic         prev_ready = 1'b0;

    always #5 clkin = ~clkin;

    seq_divide #(.WIDTH(W)) dut (
        .clkin(clkin), .rstin(rstin), .start(start),
        .dividend_in(dividend_in), .divisor_in(divisor_in),
        .busy(busy), .ready(ready), .quotient(quotient),
        .remainder(remainder), .div_by_zero(div_by_zero)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        res_t e;
`ifdef DIV_SIGNED_EN
        int sa, sv;
        sa = int'($signed(a));
        sv = int'($signed(b));
`endif
        if (b == '0) begin
            e.q = '1;
            e.r = a;
            e.dz = 1'b1;
        end else begin
`ifdef DIV_SIGNED_EN
            e.q = W'(sa / sv);
            e.r = W'(sa % sv);
`else
            e.q = a / b;
            e.r = a % b;
`endif
            e.dz = 1'b0;
        end
        return e;
    endfunction

    // Compare each result when ready rises.
    always @(negedge clkin) begin
        if (ready && !prev_ready) begin
            if (sb.size() == 0) check("sb_underflow", 32'd1, 32'd0);
            else begin
                exp_r = sb.pop_front();
                check("quotient", quotient, exp_r.q);
                check("remainder", remainder, exp_r.r);
                check("div_by_zero", div_by_zero, exp_r.dz);
            end
        end
        prev_ready = ready;
    end

    task automatic run(input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        @(negedge clkin);
        start = 1'b1;
        dividend_in = a;
        divisor_in = b;
        @(posedge clkin);
        sb.push_back(model(a, b));
        #1 start = 1'b0;
        check("busy_acc", busy, 1);
        check("ready_drop", ready, 0);
        check("dz_clr", div_by_zero, 0);
        n = 0;
        while (!ready && n < 100) begin
            @(posedge clkin);
            #1 n++;
        end
        check("latency", n, (b == '0) ? 1 : LAT);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clkin);
        check("rst_busy", busy, 0);
        check("rst_ready", ready, 0);
        check("rst_q", quotient, 0);
        check("rst_r", remainder, 0);
        check("rst_dz", div_by_zero, 0);
        rstin = 1'b0;
        // A start pulse with other operands while busy must be ignored.
        fork
            run(8'd100, 8'd7);
            begin
                repeat (3) @(negedge clkin);
                start = 1'b1;
                dividend_in = 8'd9;
                divisor_in = 8'd2;
                @(negedge clkin);
                start = 1'b0;
            end
        join
        repeat (3) @(negedge clkin);
        check("hold_q", quotient, model(8'd100, 8'd7).q);
        check("hold_r", remainder, model(8'd100, 8'd7).r);
        check("hold_busy", busy, 0);
        check("hold_ready", ready, 1);
        run(8'd255, 8'd1);
        run(8'd5, 8'd9);
        run(8'd200, 8'd200);
        run(8'd37, 8'd0);
        run(8'd10, 8'd3);
        // Reset four cycles into a division.
        @(negedge clkin);
        start = 1'b1;
        dividend_in = 8'd100;
        divisor_in = 8'd7;
        @(posedge clkin);
        #1 start = 1'b0;
        repeat (3) @(posedge clkin);
        #1 rstin = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", ready, 0);
        check("mid_rst_q", quotient, 0);
        check("mid_rst_r", remainder, 0);
        check("mid_rst_dz", div_by_zero, 0);
        @(negedge clkin);
        rstin = 1'b0;
        run(8'd50, 8'd5);
        run(8'h9C, 8'd7);
        run(8'h80, 8'hFF);
        run(8'd100, 8'hF9);
        for (int i = 0; i < 6; i++) run(W'($urandom), W'($urandom_range(0, 255)));
        repeat (3) @(negedge clkin);
        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
